pipe_stage_latch: RTL
=====================

// Module: pipe_stage_latch
// PURPOSE
//  Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying instruction, PC and control sideband.
//  Adds valid/ready handshake, stall hold, flush-to-NOP, a saturating bubble counter and an optional skid entry.
//  Sits between two pipeline stages; the hazard unit drives i_stall/i_flush, and the next stage drives i_ready.
// PARAMETERS
//  NB_INSTRUCT  32            instruction width
//  NB_PC        9             PC width
//  NB_CTRL      8             control sideband width (0 not allowed; min 1)
//  NOP_INSTR    32'h0000_0000 value loaded into instruction on flush/reset
//  NB_CNT       16            bubble counter width
// PORTS
//  i_clk          in   1           clock
//  i_reset        in   1           synchronous reset, active-high
//  i_flush        in   1           kill stage contents (branch/jump taken)
//  i_stall        in   1           hold stage contents, refuse new input
//  i_valid        in   1           upstream data valid
//  o_ready        out  1           stage can accept this cycle
//  i_instruction  in   NB_INSTRUCT upstream instruction
//  i_pc           in   NB_PC       upstream PC
//  i_ctrl         in   NB_CTRL     upstream control bits
//  o_valid        out  1           stage holds valid data
//  i_ready        in   1           downstream accepts
//  o_instruction  out  NB_INSTRUCT registered instruction
//  o_pc           out  NB_PC       registered PC
//  o_ctrl         out  NB_CTRL     registered control (all zero when not valid)
//  o_bubble_cnt   out  NB_CNT      count of cycles a bubble (invalid) was presented downstream, saturating
// BEHAVIOUR
//  - Reset is synchronous, active-high on i_reset, clock i_clk. Reset values: o_valid=0, o_instruction=NOP_INSTR, o_pc=0, o_ctrl=0, o_bubble_cnt=0, skid empty.
//  - Accept = i_valid & o_ready; Release = o_valid & i_ready. Latency in->out: 1 cycle.
//  - Priority per cycle: i_reset > i_flush > i_stall > normal.
//  - Flush: o_valid<=0, o_instruction<=NOP_INSTR, o_ctrl<=0, o_pc<=0, skid cleared; input in same cycle is dropped; o_ready=0 that cycle.
//  - Stall (no flush): all registers hold; o_ready=0; o_valid unchanged, so a valid entry is still offered downstream and may be released; if released, o_valid<=0 and o_ctrl<=0.
//  - Normal: main register loads on Accept when empty or when Release occurs in the same cycle (simultaneous in/out = pass-through, no bubble).
//  - Normal, Release without Accept: o_valid<=0, o_ctrl<=0; instruction/PC hold last value (don't care).
//  - o_ctrl is forced to 0 whenever o_valid=0 so downstream write-enables never fire on bubbles.
//  - o_bubble_cnt increments each cycle o_valid=0 & i_ready=1 & !i_reset; saturates at all-ones, no wrap. Flush does not clear it.
//  - PC is loaded with the instruction on every accept (both travel together).
// CONFIGURATION
//  - Macro PIPE_STAGE_SKID_EN defined: one-entry skid buffer behind main register.
//    o_ready = !i_stall & skid_empty, registered (no comb path i_ready->o_ready).
//    Accept while main valid and !i_ready -> data goes to skid; next Release refills main from skid first.
//    Throughput 1/cycle; 2 entries max; skid never overwritten.
//  - Undefined: no skid; o_ready = !i_stall & !i_flush & (!o_valid | i_ready) (combinational from i_ready).
// STRUCTURE
//  - Package pipe_pkg: NOP_INSTR default, typedef stage_payload_t {instr, pc, ctrl}, ctrl bit-position constants.
//  - Sub-module pipe_skid_buf (one-entry holding register + full flag), instantiated only under PIPE_STAGE_SKID_EN.
// TESTING
//  1 Reset: assert i_reset 2 cycles with i_valid=1 -> o_valid=0, o_instruction=NOP_INSTR, o_pc=0, o_bubble_cnt=0.
//  2 Stream: i_valid=1, i_ready=1, instr 0x20080005..+1 per cycle, pc 0..7 -> same sequence out 1 cycle later, no gaps, bubble count constant.
//  3 Stall: stall 3 cycles while holding 0x8C010004/pc=4 -> outputs hold 3 cycles, o_ready=0, upstream data not lost after release.
//  4 Flush: i_flush with i_stall=1 and i_valid=1 -> next cycle o_valid=0, o_instruction=0, o_ctrl=0; flush beats stall.
//  5 Backpressure (SKID_EN): i_ready=0 for 2 cycles during stream -> at most 1 extra accepted, order preserved, no drop/duplicate.
//  6 Saturation: NB_CNT=4, 20 idle cycles with i_ready=1 -> o_bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic inter-stage pipeline register.
//   - Default payload widths and the default NOP instruction encoding.
//   - stage_payload_t: instruction/PC/control bundle at the default widths.
//   - Bit positions of the control sideband as decoded by later stages.
// ----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned NB_INSTRUCT_DEF = 32;
  localparam int unsigned NB_PC_DEF       = 9;
  localparam int unsigned NB_CTRL_DEF     = 8;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [NB_INSTRUCT_DEF-1:0] instr;
    logic [NB_PC_DEF-1:0]       pc;
    logic [NB_CTRL_DEF-1:0]     ctrl;
  } stage_payload_t;

  // Control sideband bit positions
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_JUMP       = 5;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_HALT       = 7;

endpackage

// File: rtl/pipe_skid_buf.sv
// ----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry holding register with a full flag. Catches a word accepted while
// the main stage register is occupied and blocked downstream.
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset (empties the entry)
//   clear      synchronous flush (empties the entry)
//   push       write push_data; ignored while full so the entry is never
//              overwritten
//   pop        release the entry
//   push_data  word to store
//   full       entry holds data
//   data       stored word
// ----------------------------------------------------------------------------
module pipe_skid_buf #(
  parameter int unsigned NB_DATA = 49
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [NB_DATA-1:0] push_data,
  output logic               full,
  output logic [NB_DATA-1:0] data
);

  logic               full_q;
  logic [NB_DATA-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full_q <= 1'b0;
    end else if (push && !full_q) begin
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  // Payload needs no reset; full_q qualifies it.
  always_ff @(posedge clk) begin
    if (push && !full_q) begin
      data_q <= push_data;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// ----------------------------------------------------------------------------
// pipe_stage_latch
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB)
// carrying instruction, PC and control sideband with a valid/ready
// handshake, stall hold, flush-to-NOP and a saturating bubble counter.
// Priority per cycle: i_reset > i_flush > i_stall > normal.
//
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid buffer
// behind the main register. o_ready then no longer depends combinationally
// on i_ready. Without it, o_ready = !i_stall & !i_flush & (!o_valid | i_ready).
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_flush                  kill stage contents (drops same-cycle input)
//   i_stall                  hold contents, refuse new input
//   i_valid / o_ready        upstream handshake
//   i_instruction/i_pc/i_ctrl upstream payload
//   o_valid / i_ready        downstream handshake
//   o_instruction/o_pc/o_ctrl registered payload (o_ctrl zero when invalid)
//   o_bubble_cnt             saturating count of bubbles offered downstream
// ----------------------------------------------------------------------------
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int unsigned             NB_INSTRUCT = 32,
  parameter int unsigned             NB_PC       = 9,
  parameter int unsigned             NB_CTRL     = 8,
  parameter logic [NB_INSTRUCT-1:0] NOP_INSTR   = NB_INSTRUCT'(NOP_INSTR_DEF),
  parameter int unsigned             NB_CNT      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NB_INSTRUCT-1:0] i_instruction,
  input  logic [NB_PC-1:0]       i_pc,
  input  logic [NB_CTRL-1:0]     i_ctrl,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NB_INSTRUCT-1:0] o_instruction,
  output logic [NB_PC-1:0]       o_pc,
  output logic [NB_CTRL-1:0]     o_ctrl,
  output logic [NB_CNT-1:0]      o_bubble_cnt
);

  logic                   valid_q, valid_d;
  logic [NB_INSTRUCT-1:0] instr_q, instr_d;
  logic [NB_PC-1:0]       pc_q, pc_d;
  logic [NB_CTRL-1:0]     ctrl_q, ctrl_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;

  logic ready;
  logic accept;
  logic take_out;

`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned NB_PAY = NB_INSTRUCT + NB_PC + NB_CTRL;

  logic              skid_full;
  logic              skid_push;
  logic              skid_pop;
  logic              skid_clear;
  logic [NB_PAY-1:0] skid_data;

  pipe_skid_buf #(
    .NB_DATA (NB_PAY)
  ) u_skid (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (skid_clear),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data ({i_instruction, i_pc, i_ctrl}),
    .full      (skid_full),
    .data      (skid_data)
  );

  // Depends only on registered state and hazard inputs, never on i_ready.
  assign ready = !i_stall && !i_flush && !skid_full;
`else
  assign ready = !i_stall && !i_flush && (!valid_q || i_ready);
`endif

  assign accept   = i_valid && ready;
  assign take_out = valid_q && i_ready;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
`endif

    if (i_reset || i_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = '0;
      ctrl_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else if (i_stall) begin
      // Held entry may still drain downstream; nothing new comes in.
      if (take_out) begin
`ifdef PIPE_STAGE_SKID_EN
        if (skid_full) begin
          {instr_d, pc_d, ctrl_d} = skid_data;
          skid_pop = 1'b1;
        end else begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end
`else
        valid_d = 1'b0;
        ctrl_d  = '0;
`endif
      end
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (take_out) begin
        if (skid_full) begin
          // Skid is older than anything upstream; refill from it first.
          {instr_d, pc_d, ctrl_d} = skid_data;
          skid_pop = 1'b1;
        end else if (accept) begin
          instr_d = i_instruction;
          pc_d    = i_pc;
          ctrl_d  = i_ctrl;
        end else begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end
      end else if (accept) begin
        if (valid_q) begin
          skid_push = 1'b1;
        end else begin
          valid_d = 1'b1;
          instr_d = i_instruction;
          pc_d    = i_pc;
          ctrl_d  = i_ctrl;
        end
      end
`else
      // accept already implies the register is empty or draining.
      if (accept) begin
        valid_d = 1'b1;
        instr_d = i_instruction;
        pc_d    = i_pc;
        ctrl_d  = i_ctrl;
      end else if (take_out) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
`endif
    end
  end

  // Bubble counter: survives flush, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_reset) begin
      cnt_d = '0;
    end else if (!valid_q && i_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    valid_q <= valid_d;
    instr_q <= instr_d;
    pc_q    <= pc_d;
    ctrl_q  <= ctrl_d;
    cnt_q   <= cnt_d;
  end

  assign o_ready       = ready;
  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_ctrl        = valid_q ? ctrl_q : '0;
  assign o_bubble_cnt  = cnt_q;

endmodule
